uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's uart_tx.
- Frame format: line idle high, one start bit (0), 8 data bits LSB first, one stop bit (1).
- Samples the asynchronous serial line through a 2-FF synchroniser and checks the start bit at mid-bit.
- Presents each received byte on a parallel bus with a one-cycle valid strobe, and flags framing errors.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per bit period; must be even and >= 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rx_in  input  1  serial line, asynchronous to clk, idle high.
- rx_data  output  8  last correctly received byte; held until the next good frame.
- rx_valid  output  1  one-cycle pulse; rx_data is new this cycle.
- rx_frame_err  output  1  one-cycle pulse; stop bit sampled as 0.
- rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_busy=0, both synchroniser FFs=1, bit counter=0, clk counter=0, shift register=0.
- Synchroniser: rx_in -> s1 -> rx_s. rx_s at edge k equals rx_in as sampled at edge k-2. All FSM decisions use rx_s only.
- Let C = CLKS_PER_BIT, with a counter cnt of width $clog2(C) and a 3-bit bit index idx.
- States and transitions:
  - IDLE: if rx_s==0, go to START with cnt<=0. Otherwise stay.
  - START: if cnt==C/2-1, check rx_s:
    - rx_s==0: go to DATA, cnt<=0, idx<=0.
    - rx_s==1: glitch; go to IDLE with no output pulse.
    - Otherwise cnt++.
  - DATA: if cnt==C-1, shift rx_s into the shift register MSB (shift right, so bit 0 ends up as the first received bit) and set cnt<=0.
    - If idx==7, go to STOP; otherwise idx++.
    - If cnt!=C-1, cnt++.
  - STOP: if cnt==C-1:
    - rx_s==1: rx_data<=shift register, rx_valid<=1, go to IDLE.
    - rx_s==0: rx_frame_err<=1, rx_data unchanged, go to BREAK.
    - Otherwise cnt++.
  - BREAK: stay until rx_s==1, then go to IDLE. Prevents a held-low line from being decoded as a stream of 0x00 frames.
- Pulses: rx_valid and rx_frame_err are high for exactly one cycle and never high together.
- rx_busy is combinational from state (state != IDLE).
- Timing: if edge k is where IDLE sees rx_s==0:
  - start check at edge k+C/2;
  - data bit n sampled at edge k+C/2+(n+1)*C;
  - stop bit sampled at edge k+C/2+9C;
  - rx_valid / rx_frame_err high in the cycle following that edge.
  - With t0 = first edge that samples rx_in low, k = t0+2.
- Back-to-back frames: a new start bit is accepted in the first IDLE cycle after STOP. Stop-bit sampling at mid-bit leaves C/2 cycles of margin.
- Reset mid-frame: immediate return to reset values; no partial byte is ever presented.
- Line noise: a low pulse shorter than C/2 cycles is rejected at the START check. Data bits are single-sampled at mid-bit; no majority vote.

Test Plan:
1. Reset, then send 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) at 16 clk/bit, starting low at edge t0 -> rx_valid single pulse in the cycle after edge t0+154; rx_data=8'hA5; rx_frame_err never high.
2. Two back-to-back frames 0x00 then 0xFF with no idle gap -> exactly two rx_valid pulses 160 cycles apart; rx_data reads 8'h00, then 8'hFF; rx_busy drops for at least one cycle between frames.
3. rx_in low for 5 cycles, then high -> START rejects the glitch; state back to IDLE; no rx_valid or rx_frame_err; rx_busy high for about 8 cycles only.
4. Send 0x3C with stop bit forced 0, line held low for 40 more cycles, then high, then a valid 0x81 -> one rx_frame_err pulse; rx_data stays at its previous value; state stays BREAK until the line goes high; then rx_valid with rx_data=8'h81.
5. Assert rst low during data bit 4 of a frame, release after 3 cycles with the line idle -> all outputs at reset values immediately; no rx_valid; next clean frame 0x5A received correctly.
6. Set CLKS_PER_BIT=4, send 0xC3 -> rx_valid in the cycle after edge t0+2+2+36; rx_data=8'hC3.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised line, mid-bit start check, single-sample data,
// one-cycle valid / framing-error strobes and a BREAK state that waits out a held-low line.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic [2:0]    state;
  logic          s1;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1           <= 1'b1;
      rx_s         <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      s1           <= rx_in;
      rx_s         <= s1;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            // A line that is high again at mid start bit was only a glitch.
            if (!rx_s) begin
              state <= DATA;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= '0;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 16 clk/bit and one at 4 clk/bit.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rx16, rx4;
  logic [7:0] rx_data16, rx_data4;
  logic       rx_valid16, rx_valid4;
  logic       rx_frame_err16, rx_frame_err4;
  logic       rx_busy16, rx_busy4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int n_valid16 = 0, n_err16 = 0, n_both16 = 0, busy_neg16 = 0;
  int last_valid_cyc16 = 0, last_err_cyc16 = 0;
  logic [7:0] last_data16 = 8'h00;
  int n_valid4 = 0, n_err4 = 0, last_valid_cyc4 = 0;
  logic [7:0] last_data4 = 8'h00;

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rst(rst), .rx_in(rx16), .rx_data(rx_data16),
    .rx_valid(rx_valid16), .rx_frame_err(rx_frame_err16), .rx_busy(rx_busy16)
  );

  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .rx_in(rx4), .rx_data(rx_data4),
    .rx_valid(rx_valid4), .rx_frame_err(rx_frame_err4), .rx_busy(rx_busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Pulse monitor: cyc at a negedge is the number of the edge just passed.
  always @(negedge clk) begin
    if (rx_valid16) begin
      n_valid16++;
      last_valid_cyc16 = cyc;
      last_data16 = rx_data16;
    end
    if (rx_frame_err16) begin
      n_err16++;
      last_err_cyc16 = cyc;
    end
    if (rx_valid16 && rx_frame_err16) n_both16++;
    if (rx_busy16) busy_neg16++;
    if (rx_valid4) begin
      n_valid4++;
      last_valid_cyc4 = cyc;
      last_data4 = rx_data4;
    end
    if (rx_frame_err4) n_err4++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int c, input logic b);
    if (c == 4) rx4 = b;
    else        rx16 = b;
  endtask

  // Called #1 after an edge; t0 is the first edge that samples the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int c, output int t0);
    logic [9:0] bits;
    bits = {stop_b, d, 1'b0};
    t0 = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      drive(c, bits[i]);
      wait_cycles(c);
    end
    drive(c, 1'b1);
  endtask

  initial begin
    int t0, t1, nv, ne, bz;
    logic [7:0] bits5a;

    rst  = 1'b0;
    rx16 = 1'b1;
    rx4  = 1'b1;
    wait_cycles(3);
    chk("reset_data",  32'(rx_data16), 32'h00);
    chk("reset_valid", 32'(rx_valid16), 32'h0);
    chk("reset_err",   32'(rx_frame_err16), 32'h0);
    chk("reset_busy",  32'(rx_busy16), 32'h0);
    rst = 1'b1;
    wait_cycles(5);

    // 1: single 0xA5 frame
    nv = n_valid16; ne = n_err16;
    send_frame(8'hA5, 1'b1, 16, t0);
    chk("t1_busy_after_stop", 32'(rx_busy16), 32'h0);
    wait_cycles(4);
    chk("t1_valid_count", 32'(n_valid16 - nv), 32'd1);
    chk("t1_valid_edge",  32'(last_valid_cyc16), 32'(t0 + 154));
    chk("t1_data",        32'(last_data16), 32'hA5);
    chk("t1_rx_data",     32'(rx_data16), 32'hA5);
    chk("t1_no_err",      32'(n_err16 - ne), 32'd0);

    // 2: back-to-back 0x00 then 0xFF
    nv = n_valid16;
    send_frame(8'h00, 1'b1, 16, t0);
    chk("t2_busy_gap",   32'(rx_busy16), 32'h0);
    chk("t2_first_data", 32'(last_data16), 32'h00);
    t1 = last_valid_cyc16;
    send_frame(8'hFF, 1'b1, 16, t0);
    wait_cycles(4);
    chk("t2_valid_count", 32'(n_valid16 - nv), 32'd2);
    chk("t2_spacing",     32'(last_valid_cyc16 - t1), 32'd160);
    chk("t2_second_data", 32'(last_data16), 32'hFF);

    // 3: 5-cycle glitch rejected at the start check
    nv = n_valid16; ne = n_err16; bz = busy_neg16;
    rx16 = 1'b0;
    wait_cycles(5);
    rx16 = 1'b1;
    wait_cycles(30);
    chk("t3_no_valid",   32'(n_valid16 - nv), 32'd0);
    chk("t3_no_err",     32'(n_err16 - ne), 32'd0);
    chk("t3_idle",       32'(rx_busy16), 32'h0);
    chk("t3_busy_width", 32'(busy_neg16 - bz), 32'd8);
    chk("t3_data_held",  32'(rx_data16), 32'hFF);

    // 4: framing error, held-low line, recovery with 0x81
    nv = n_valid16; ne = n_err16;
    send_frame(8'h3C, 1'b0, 16, t0);
    rx16 = 1'b0;
    wait_cycles(40);
    chk("t4_err_count",  32'(n_err16 - ne), 32'd1);
    chk("t4_err_edge",   32'(last_err_cyc16), 32'(t0 + 154));
    chk("t4_no_valid",   32'(n_valid16 - nv), 32'd0);
    chk("t4_data_held",  32'(rx_data16), 32'hFF);
    chk("t4_break_busy", 32'(rx_busy16), 32'h1);
    rx16 = 1'b1;
    wait_cycles(6);
    chk("t4_break_exit", 32'(rx_busy16), 32'h0);
    chk("t4_single_err", 32'(n_err16 - ne), 32'd1);
    send_frame(8'h81, 1'b1, 16, t0);
    wait_cycles(4);
    chk("t4_valid_edge", 32'(last_valid_cyc16), 32'(t0 + 154));
    chk("t4_data",       32'(rx_data16), 32'h81);

    // 5: reset during data bit 4
    nv = n_valid16;
    bits5a = 8'h5A;
    rx16 = 1'b0;
    wait_cycles(16);
    for (int i = 0; i < 4; i++) begin
      rx16 = bits5a[i];
      wait_cycles(16);
    end
    rx16 = bits5a[4];
    wait_cycles(8);
    rst  = 1'b0;
    rx16 = 1'b1;
    #1;
    chk("t5_rst_data",  32'(rx_data16), 32'h00);
    chk("t5_rst_valid", 32'(rx_valid16), 32'h0);
    chk("t5_rst_err",   32'(rx_frame_err16), 32'h0);
    chk("t5_rst_busy",  32'(rx_busy16), 32'h0);
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(20);
    chk("t5_no_partial", 32'(n_valid16 - nv), 32'd0);
    chk("t5_data_clear", 32'(rx_data16), 32'h00);
    send_frame(8'h5A, 1'b1, 16, t0);
    wait_cycles(4);
    chk("t5_valid_count", 32'(n_valid16 - nv), 32'd1);
    chk("t5_data",        32'(rx_data16), 32'h5A);

    // 6: 4 clk/bit instance
    nv = n_valid4;
    send_frame(8'hC3, 1'b1, 4, t0);
    wait_cycles(6);
    chk("t6_valid_count", 32'(n_valid4 - nv), 32'd1);
    chk("t6_valid_edge",  32'(last_valid_cyc4), 32'(t0 + 40));
    chk("t6_data",        32'(last_data4), 32'hC3);
    chk("t6_no_err",      32'(n_err4), 32'd0);

    chk("never_both", 32'(n_both16), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
